// File: rtl/beat_sequencer_if.sv
// -----------------------------------------------------------------------------
// beat_sequencer_if
//
// Purpose: bundles the command inputs and beat-index outputs of the beat
// sequencer. The sequencer drives the beat side. The button/one-pulse logic
// (or a testbench) drives the command side.
//
// Signals:
//   start, stop, pause : one-cycle command pulses into the sequencer
//   loop               : level, wrap the score instead of finishing
//   tempo_sel [1:0]    : tempo select (0/3 nominal, 1 double, 2 half)
//   ibeatNum [BEAT_W]  : current beat index to the score ROMs
//   en                 : high only while playing
//   beat_tick          : one-cycle pulse when a new ibeatNum appears
//   done               : one-cycle pulse when a non-looping score ends
//   state [1:0]        : 0 IDLE, 1 PLAY, 2 PAUSE, 3 COUNTIN
//   countin            : high during the optional count-in
//
// Modports:
//   master : sequencer side (commands in, beat index out)
//   slave  : controller side (commands out, beat index in)
// -----------------------------------------------------------------------------
interface beat_sequencer_if #(
  parameter int BEAT_W = 12
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop;
  logic [1:0]        tempo_sel;
  logic [BEAT_W-1:0] ibeatNum;
  logic              en;
  logic              beat_tick;
  logic              done;
  logic [1:0]        state;
  logic              countin;

  modport master (
    input  start, stop, pause, loop, tempo_sel,
    output ibeatNum, en, beat_tick, done, state, countin
  );

  modport slave (
    output start, stop, pause, loop, tempo_sel,
    input  ibeatNum, en, beat_tick, done, state, countin
  );
endinterface

// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
//
// Purpose: initiator of the beat-indexed score interface. It divides the
// system clock into beat periods at a selectable tempo. It steps ibeatNum from
// 0 to LEN-1 and runs a play/pause/stop state machine with optional looping.
// The tone-lookup ROMs downstream are pure functions of ibeatNum. They play
// silence whenever en is low.
//
// Parameters:
//   CLK_FREQ : system clock in Hz
//   BEAT_HZ  : beats per second at nominal tempo (DIV = CLK_FREQ/BEAT_HZ)
//   LEN      : beats per score (2..4096)
//   BEAT_W   : width of the beat index
//
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : beat_sequencer_if.master (commands in, beat index/status out)
//
// Optional feature macro: BEAT_SEQUENCER_COUNTIN_EN
//   When defined, start from IDLE first runs four count-in beats (COUNTIN
//   state, countin = 1, beat_tick on each count) before playback begins.
//   When undefined, countin is tied low and start goes straight to PLAY.
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module beat_sequencer #(
  parameter int CLK_FREQ = 100000000,
  parameter int BEAT_HZ  = 8,
  parameter int LEN      = 64,
  parameter int BEAT_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  beat_sequencer_if.master bus
);

  // Clocks per beat for each tempo. The fast period rounds down and never
  // drops below one clock.
  localparam logic [31:0] DIV      = 32'(CLK_FREQ / BEAT_HZ);
  localparam logic [31:0] DIV_FAST = ((DIV >> 1) == 32'd0) ? 32'd1 : (DIV >> 1);
  localparam logic [31:0] DIV_SLOW = DIV << 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    PAUSE   = 2'd2,
    COUNTIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       div_q, div_d;
  logic [31:0]       period_q, period_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              en_q;
  logic              terminal;

`ifdef BEAT_SEQUENCER_COUNTIN_EN
  logic [1:0]        cnt_q, cnt_d;
  logic              countin_q;
`endif

  // Map the tempo select onto a beat period. Codes 0 and 3 are both nominal.
  function automatic logic [31:0] tempo_period(input logic [1:0] sel);
    case (sel)
      2'd1:    tempo_period = DIV_FAST;
      2'd2:    tempo_period = DIV_SLOW;
      default: tempo_period = DIV;
    endcase
  endfunction

  // The divider is on the last clock of the current beat.
  assign terminal = (div_q == (period_q - 32'd1));

  // Next-state logic. Commands are checked in the order stop, start, pause,
  // so a command always beats a terminal count in the same cycle. The period
  // is re-latched only at beat boundaries. A tempo change therefore never
  // shortens or stretches the beat that is already playing.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    period_d = period_q;
    beat_d   = beat_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
`ifdef BEAT_SEQUENCER_COUNTIN_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        div_d  = '0;
        beat_d = '0;
        if (bus.start && !bus.stop) begin
          period_d = tempo_period(bus.tempo_sel);
`ifdef BEAT_SEQUENCER_COUNTIN_EN
          state_d  = COUNTIN;
          cnt_d    = 2'd0;
`else
          state_d  = PLAY;
`endif
        end
      end

      PLAY: begin
        if (bus.stop) begin
          state_d = IDLE;
          div_d   = '0;
          beat_d  = '0;
        end else if (bus.start) begin
          // A restart jumps back to beat 0 without announcing a new beat.
          div_d  = '0;
          beat_d = '0;
        end else if (bus.pause) begin
          // Freeze before any increment. A pending terminal count fires on
          // the first PLAY cycle after resume.
          state_d = PAUSE;
        end else if (terminal) begin
          div_d    = '0;
          period_d = tempo_period(bus.tempo_sel);
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (bus.loop) begin
              tick_d = 1'b1;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            tick_d = 1'b1;
          end
        end else begin
          div_d = div_q + 32'd1;
        end
      end

      PAUSE: begin
        if (bus.stop) begin
          state_d = IDLE;
          div_d   = '0;
          beat_d  = '0;
        end else if (bus.start || bus.pause) begin
          // Resume from the frozen divider value. The terminal compare runs
          // again on the next cycle, not on this one.
          state_d = PLAY;
        end
      end

      COUNTIN: begin
`ifdef BEAT_SEQUENCER_COUNTIN_EN
        beat_d = '0;
        if (bus.stop) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (terminal) begin
          div_d  = '0;
          tick_d = 1'b1;
          if (cnt_q == 2'd3) begin
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          div_d = div_q + 32'd1;
        end
`else
        // This state is unreachable in this build. Recover to IDLE.
        state_d = IDLE;
        div_d   = '0;
        beat_d  = '0;
`endif
      end

      default: begin
        state_d = IDLE;
        div_d   = '0;
        beat_d  = '0;
      end
    endcase
  end

  // State and output registers. en and countin are derived from the next
  // state, so they line up with the state output on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      period_q <= DIV;
      beat_q   <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      period_q <= period_d;
      beat_q   <= beat_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      en_q     <= (state_d == PLAY);
    end
  end

`ifdef BEAT_SEQUENCER_COUNTIN_EN
  // Count-in beat counter and its status flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 2'd0;
      countin_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      countin_q <= (state_d == COUNTIN);
    end
  end

  assign bus.countin = countin_q;
`else
  assign bus.countin = 1'b0;
`endif

  assign bus.ibeatNum  = beat_q;
  assign bus.en        = en_q;
  assign bus.beat_tick = tick_q;
  assign bus.done      = done_q;
  assign bus.state     = state_q;

endmodule
